// File: rtl/ahb_pkg.sv
// Shared AHB encodings, slave FSM state names and the wait-counter width helper.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } slv_state_t;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;

   // Wide enough to hold WAIT_STATES, never narrower than one bit.
   function automatic int cnt_width(input int w);
      int r;
      r = $clog2(w + 1);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/ahb_wait_cnt.sv
// Loadable down-counter for data-phase wait states; done flags the final wait cycle.
module ahb_wait_cnt
   import ahb_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   localparam int CW = cnt_width(WAIT_STATES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          done
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == CW'(1));

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB read-slave address-phase controller with wait-state insertion.
// Define AHB_SLV_ERR_RESP_EN to give invalid transfers a two-cycle ERROR response.
module ahb_slave_ctrl
   import ahb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              hsel_x,
   input  logic [ADDR_W-1:0] haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic              hready_in,
   output logic              hreadyout,
   output logic              hresp,
   output logic [1:0]        read_select,
   output logic              hwrite_q,
   output logic              rd_strobe
);

   localparam int CW = cnt_width(WAIT_STATES);
   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_WAIT = ST_WAIT;
`ifdef AHB_SLV_ERR_RESP_EN
   localparam logic [1:0] S_ERR1 = ST_ERR1;
   localparam logic [1:0] S_ERR2 = ST_ERR2;
`endif

   logic [1:0] state;
   logic       accept;
   logic       xfer_ok;
   logic       cnt_done;

   // Gating with our own ready keeps a misbehaving bus from re-entering mid data phase.
   assign accept = hsel_x && hready_in && hreadyout &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

`ifdef AHB_SLV_ERR_RESP_EN
   assign xfer_ok   = (haddr[ADDR_W-1:2] == '0) && (hsize == HSIZE_BYTE) && !hwrite;
   assign hreadyout = (state != S_WAIT) && (state != S_ERR1);
   assign hresp     = ((state == S_ERR1) || (state == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
   logic unused_addr_size;
   assign unused_addr_size = ^{haddr[ADDR_W-1:2], hsize};
   assign xfer_ok   = 1'b1;
   assign hreadyout = (state != S_WAIT);
   assign hresp     = HRESP_OKAY;
`endif

   ahb_wait_cnt #(
      .WAIT_STATES(WAIT_STATES)
   ) u_wait_cnt (
      .clk      (hclk),
      .reset    (hreset),
      .load     (accept && xfer_ok),
      .load_val (CW'(WAIT_STATES)),
      .done     (cnt_done)
   );

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state       <= S_IDLE;
         read_select <= 2'b00;
         hwrite_q    <= 1'b0;
         rd_strobe   <= 1'b0;
      end else begin
         rd_strobe <= 1'b0;
         if (accept) begin
            read_select <= haddr[1:0];
            hwrite_q    <= hwrite;
         end
         case (state)
            S_WAIT: begin
               if (cnt_done) begin
                  state     <= S_IDLE;
                  rd_strobe <= !hwrite_q;
               end
            end
`ifdef AHB_SLV_ERR_RESP_EN
            S_ERR1: state <= S_ERR2;
`endif
            // IDLE and ERR2 both present hreadyout=1 and take a new address phase.
            default: begin
               state <= S_IDLE;
               if (accept) begin
`ifdef AHB_SLV_ERR_RESP_EN
                  if (!xfer_ok) begin
                     state <= S_ERR1;
                  end else
`endif
                  if (WAIT_STATES > 0) begin
                     state <= S_WAIT;
                  end else begin
                     rd_strobe <= !hwrite;
                  end
               end
            end
         endcase
      end
   end

endmodule
